// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter for one shared resource.
// The owner keeps the grant until it asserts done, drops its request, or
// has held the resource for MAX_HOLD consecutive cycles (0 = no limit).
// Outputs are registered. grant, grant_idx and grant_valid always update
// together.
//
// Handshake: req[i] is a level request. The requester owns the resource
// while grant[i] is high. done is sampled only while a grant is active and
// releases the current owner on the next clock edge.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_grant;
  logic [2:0]    r_grant_idx;
  logic          r_grant_valid;
  logic          r_timeout;

  logic [2:0]    w_search_ptr;
  logic [3:0]    w_win;
  logic          w_win_found;
  logic [2:0]    w_win_idx;
  logic          w_rel_done;
  logic          w_rel_drop;
  logic          w_rel_hold;
  logic          w_release;

  logic [7:0]    w_grant_nxt;
  logic [2:0]    w_grant_idx_nxt;
  logic          w_grant_valid_nxt;
  logic          w_timeout_nxt;
  logic [2:0]    w_ptr_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Scan r starting just after p, ascending with wrap; p itself is checked last.
  // Returns {found, index}.
  function automatic logic [3:0] find_winner(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = p + 3'(k);
      if (!res[3] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Release conditions and the winner search (from the owner on a release).
  always_comb begin
    w_rel_done   = done;
    w_rel_drop   = !req[r_grant_idx];
    w_rel_hold   = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);
    w_release    = (r_state == S_GRANT) && (w_rel_done || w_rel_drop || w_rel_hold);
    w_search_ptr = (r_state == S_GRANT) ? r_grant_idx : r_ptr;
    w_win        = find_winner(req, w_search_ptr);
    w_win_found  = w_win[3];
    w_win_idx    = w_win[2:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_win_found) w_state_nxt = S_GRANT;
      S_GRANT: if (w_release && !w_win_found) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_grant_nxt       = r_grant;
    w_grant_idx_nxt   = r_grant_idx;
    w_grant_valid_nxt = r_grant_valid;
    w_timeout_nxt     = 1'b0;
    w_ptr_nxt         = r_ptr;
    w_cnt_nxt         = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_grant_nxt       = 8'b1 << w_win_idx;
          w_grant_idx_nxt   = w_win_idx;
          w_grant_valid_nxt = 1'b1;
          w_cnt_nxt         = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_ptr_nxt     = r_grant_idx;
          // Only a pure hold-limit release counts as a timeout.
          w_timeout_nxt = w_rel_hold && !w_rel_done && !w_rel_drop;
          w_cnt_nxt     = '0;
          if (w_win_found) begin
            w_grant_nxt       = 8'b1 << w_win_idx;
            w_grant_idx_nxt   = w_win_idx;
            w_grant_valid_nxt = 1'b1;
          end else begin
            w_grant_nxt       = '0;
            w_grant_idx_nxt   = '0;
            w_grant_valid_nxt = 1'b0;
          end
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, pointer and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_ptr         <= 3'd7;
      r_cnt         <= '0;
    end else begin
      r_grant       <= w_grant_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_timeout     <= w_timeout_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule
